sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Shares one single-port sram (registered sram_ready, 1-cycle read) between two picorv32-style
//  native-memory requesters: m0 = CPU, m1 = loader/DMA. Round-robin grant, one access in flight.
//  Sequences sram_sel and hides the stale sram_ready that follows every access. A timeout
//  bounds a hung access.
// PARAMETERS
//  ADDRWIDTH  13  byte-address width of the sram port (8 KiB)
//  TIMEOUT    16  max cycles in ACCESS before forced completion; must be >= 2
// PORTS
//  clk         in   1          single clock; all logic on posedge
//  reset       in   1          synchronous, active-high
//  m0_valid    in   1          requester 0 request; held until m0_ready
//  m0_addr     in   32         byte address; bits [1:0] and [31:ADDRWIDTH] ignored (aliasing)
//  m0_wdata    in   32         write data
//  m0_wstrb    in   4          byte enables; 4'b0000 = read
//  m0_ready    out  1          1-cycle completion pulse
//  m0_rdata    out  32         read data, valid while m0_ready=1
//  m1_*        --   --         identical set for requester 1
//  sram_sel    out  1          access strobe to sram
//  sram_addr   out  ADDRWIDTH  latched address, [1:0] forced 0
//  sram_wdata  out  32         latched write data
//  sram_wstrb  out  4          latched byte enables
//  sram_ready  in   1          sram completion (registered copy of sram_sel)
//  sram_rdata  in   32         sram read data
//  err         out  1          1-cycle pulse when an access completes by timeout
// BEHAVIOUR
//  - FSM IDLE -> ACCESS -> DONE -> IDLE; one access at a time, no pipelining.
//  - IDLE: if any valid, pick grant, latch addr/wdata/wstrb/id, go ACCESS. sram_sel=0.
//  - Round-robin: both valid -> requester != last_grant; one valid -> that one. last_grant
//    updates on grant only.
//  - ACCESS: sram_sel=1, fields held stable. On sram_ready=1 latch sram_rdata, go DONE.
//    Timeout counter clears on entry; at TIMEOUT-1 without ready: rdata=32'h0, err=1, go DONE.
//  - DONE: sram_sel=0; granted mN_ready=1 with latched rdata (0 after a write). sram_ready is
//    ignored here because it is stale from ACCESS. Always go IDLE.
//  - Latency: valid sampled in IDLE at cycle T -> sel T+1 -> sram_ready T+2 -> mN_ready T+3.
//    Minimum 4 cycles per access. Back-to-back requests alternate.
//  - valid dropped while granted: the access still completes (write still performed) and the
//    ready pulse is still issued. No abort.
//  - At most one mN_ready per cycle, and only to the latched id. The other requester waits.
//  - Reset (any state, mid-access included): state=IDLE, last_grant=1 (m0 wins first),
//    counter=0. All outputs 0: sram_sel, sram_addr, sram_wdata, sram_wstrb, m*_ready,
//    m*_rdata, err. A write in flight at reset may or may not land.
// STRUCTURE
//  - Package sram_arb_pkg: state_t enum {IDLE, ACCESS, DONE}; req_id_t (1 bit);
//    RDATA_TIMEOUT = 32'h0.
//  - Sub-module rr_arb2: combinational req[1:0] + last_grant -> grant id + grant_valid.
//  - Top holds the FSM, request latches, rdata register and timeout counter
//    ($clog2(TIMEOUT) bits).
// TESTING
//  1. m0 write 0x0000_0010 = 32'hCAFE_F00D, wstrb 4'hF, then m0 read 0x10:
//     m0_ready at T+3 each time, rdata 32'hCAFE_F00D.
//  2. m0 and m1 both valid from reset, reading 0x20 and 0x24: m0 served first, then m1.
//     Both held valid continuously: strict alternation, no starvation.
//  3. Bench model with sram_ready stuck 0, TIMEOUT=16, m1 read: sram_sel high for 16
//     cycles, then m1_ready=1, rdata 32'h0, err=1 in the same cycle.
//  4. Stale-ready check: after each access, sram_ready=1 in DONE produces no extra
//     m*_ready and no FSM advance. Assert exactly one mN_ready per grant.
//  5. reset=1 in the cycle ACCESS is entered: next cycle all outputs 0 and state IDLE.
//     Then m1 and m0 both valid: m0 granted.
//  6. m1 drops valid one cycle after grant on a write of 32'h1234_5678 to 0x40: m1_ready
//     still pulses, and a later read of 0x40 returns 32'h1234_5678.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester sram arbiter.
package sram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   typedef logic req_id_t;

   localparam logic [31:0] RDATA_TIMEOUT = 32'h0;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin pick: on contention the requester that did not win last time is chosen.
module rr_arb2
   import sram_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  req_id_t    last_grant_i,
   output req_id_t    grant_id_o,
   output logic       grant_valid_o
);

   always_comb begin
      grant_valid_o = |req_i;
      if (req_i == 2'b11) begin
         grant_id_o = ~last_grant_i;
      end else begin
         grant_id_o = req_i[1];
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port sram between a CPU (m0) and a loader (m1), one access at a time,
// masking the stale sram_ready seen after each access and bounding hung accesses.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDRWIDTH = 13,
   parameter int TIMEOUT   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 m0_valid,
   input  logic [31:0]          m0_addr,
   input  logic [31:0]          m0_wdata,
   input  logic [3:0]           m0_wstrb,
   output logic                 m0_ready,
   output logic [31:0]          m0_rdata,
   input  logic                 m1_valid,
   input  logic [31:0]          m1_addr,
   input  logic [31:0]          m1_wdata,
   input  logic [3:0]           m1_wstrb,
   output logic                 m1_ready,
   output logic [31:0]          m1_rdata,
   output logic                 sram_sel,
   output logic [ADDRWIDTH-1:0] sram_addr,
   output logic [31:0]          sram_wdata,
   output logic [3:0]           sram_wstrb,
   input  logic                 sram_ready,
   input  logic [31:0]          sram_rdata,
   output logic                 err,
   output state_t               dbg_state_o
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t               state_q;
   req_id_t              last_grant_q, id_q;
   logic [CW-1:0]        cnt_q;
   logic                 sel_q, err_q;
   logic [ADDRWIDTH-1:0] addr_q;
   logic [31:0]          wdata_q;
   logic [3:0]           wstrb_q;
   logic                 m0_ready_q, m1_ready_q;
   logic [31:0]          m0_rdata_q, m1_rdata_q;

   req_id_t              grant_id;
   logic                 grant_valid;
   logic [ADDRWIDTH-1:0] addr_d;
   logic [31:0]          wdata_d, rdata_d;
   logic [3:0]           wstrb_d;
   logic                 unused_addr_bits;

   // Address bits outside the sram word window alias and are intentionally dropped.
   assign unused_addr_bits = ^{m0_addr[31:ADDRWIDTH], m0_addr[1:0],
                               m1_addr[31:ADDRWIDTH], m1_addr[1:0]};

   rr_arb2 u_rr_arb2 (
      .req_i         ({m1_valid, m0_valid}),
      .last_grant_i  (last_grant_q),
      .grant_id_o    (grant_id),
      .grant_valid_o (grant_valid)
   );

   always_comb begin
      addr_d  = grant_id ? {m1_addr[ADDRWIDTH-1:2], 2'b00} : {m0_addr[ADDRWIDTH-1:2], 2'b00};
      wdata_d = grant_id ? m1_wdata : m0_wdata;
      wstrb_d = grant_id ? m1_wstrb : m0_wstrb;
      // Writes return zero; a timed-out access returns the timeout pattern.
      if (!sram_ready) begin
         rdata_d = RDATA_TIMEOUT;
      end else if (wstrb_q == 4'b0000) begin
         rdata_d = sram_rdata;
      end else begin
         rdata_d = 32'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         cnt_q        <= '0;
         sel_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         m0_ready_q   <= 1'b0;
         m1_ready_q   <= 1'b0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_valid) begin
                  state_q      <= ACCESS;
                  last_grant_q <= grant_id;
                  id_q         <= grant_id;
                  addr_q       <= addr_d;
                  wdata_q      <= wdata_d;
                  wstrb_q      <= wstrb_d;
                  sel_q        <= 1'b1;
                  cnt_q        <= '0;
               end
            end
            ACCESS: begin
               if (sram_ready || (cnt_q == CNT_LAST)) begin
                  state_q <= DONE;
                  sel_q   <= 1'b0;
                  err_q   <= ~sram_ready;
                  if (id_q) begin
                     m1_ready_q <= 1'b1;
                     m1_rdata_q <= rdata_d;
                  end else begin
                     m0_ready_q <= 1'b1;
                     m0_rdata_q <= rdata_d;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               // sram_ready here echoes the ACCESS strobe and is deliberately ignored.
               state_q    <= IDLE;
               m0_ready_q <= 1'b0;
               m1_ready_q <= 1'b0;
               m0_rdata_q <= '0;
               m1_rdata_q <= '0;
               err_q      <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sram_sel    = sel_q;
   assign sram_addr   = addr_q;
   assign sram_wdata  = wdata_q;
   assign sram_wstrb  = wstrb_q;
   assign m0_ready    = m0_ready_q;
   assign m0_rdata    = m0_rdata_q;
   assign m1_ready    = m1_ready_q;
   assign m1_rdata    = m1_rdata_q;
   assign err         = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural 1-cycle sram that can hold sram_ready low.
module tb_sram_arbiter;
   import sram_arb_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        m0_valid = 1'b0, m1_valid = 1'b0;
   logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
   logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
   logic        m0_ready, m1_ready, sram_sel, err;
   logic [31:0] m0_rdata, m1_rdata, sram_wdata;
   logic [12:0] sram_addr;
   logic [3:0]  sram_wstrb;
   logic        sram_ready = 1'b0;
   logic [31:0] sram_rdata = '0;
   state_t      dbg_state;

   logic        stuck = 1'b0;
   logic [31:0] mem [0:2047];
   int          errors = 0, checks = 0;
   int          m0_cnt = 0, m1_cnt = 0, both_cnt = 0, sel_cnt = 0, err_cnt = 0;

   always #5 clk = ~clk;

   sram_arbiter #(.ADDRWIDTH(13), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .sram_sel(sram_sel), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_wstrb(sram_wstrb), .sram_ready(sram_ready), .sram_rdata(sram_rdata),
      .err(err), .dbg_state_o(dbg_state)
   );

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 32'hA500_0000 + i;
   end

   // Behavioural sram: registered ready, 1-cycle read, byte-lane writes.
   always @(posedge clk) begin
      sram_ready <= sram_sel && !stuck;
      if (sram_sel) begin
         if (sram_wstrb == 4'b0000) begin
            sram_rdata <= mem[sram_addr[12:2]];
         end else begin
            for (int b = 0; b < 4; b++)
               if (sram_wstrb[b]) mem[sram_addr[12:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
         end
      end
   end

   always @(negedge clk) begin
      if (m0_ready) m0_cnt++;
      if (m1_ready) m1_cnt++;
      if (m0_ready && m1_ready) both_cnt++;
      if (sram_sel) sel_cnt++;
      if (err) err_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int id, input logic v, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws);
      if (id == 0) begin
         m0_valid = v; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
      end else begin
         m1_valid = v; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
      end
   endtask

   // Issues one request and waits (bounded) for its ready; lat = -1 on expiry.
   task automatic do_access(input int id, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] ws, input int drop_after,
                            output logic [31:0] rd, output int lat, output logic err_seen);
      lat = -1; rd = 'x; err_seen = 1'b0;
      drive(id, 1'b1, a, wd, ws);
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (i == drop_after) drive(id, 1'b0, a, wd, ws);
         if ((id == 0 && m0_ready) || (id == 1 && m1_ready)) begin
            lat = i;
            rd = (id == 0) ? m0_rdata : m1_rdata;
            err_seen = err;
            break;
         end
      end
      drive(id, 1'b0, '0, '0, '0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      checks++;
      if ({sram_sel, sram_addr, sram_wdata, sram_wstrb, m0_ready, m1_ready, m0_rdata, m1_rdata, err} !== '0) begin
         errors++; $display("FAIL reset_outputs: got sel=%b addr=%h wd=%h ws=%h r0=%b r1=%b rd0=%h rd1=%h err=%b, want all 0",
            sram_sel, sram_addr, sram_wdata, sram_wstrb, m0_ready, m1_ready, m0_rdata, m1_rdata, err);
      end
      checks++;
      if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_write_read();
      logic [31:0] rd; int lat; logic e;
      do_access(0, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 0, rd, lat, e);
      checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d want 3", lat); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h want 00000000", rd); end
      tick(); tick();
      do_access(0, 32'h0000_0010, 32'h0, 4'h0, 0, rd, lat, e);
      checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d want 3", lat); end
      checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd_data: got %h want cafef00d", rd); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", e); end
      tick(); tick();
      do_access(0, 32'hFFFF_E012, 32'h0, 4'h0, 0, rd, lat, e);
      checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL alias_data: got %h want cafef00d", rd); end
      tick(); tick();
   endtask

   task automatic test_round_robin();
      int got, gap; logic [31:0] rd;
      reset = 1'b1; tick(); tick();
      reset = 1'b0;
      drive(0, 1'b1, 32'h20, '0, '0);
      drive(1, 1'b1, 32'h24, '0, '0);
      for (int k = 0; k < 6; k++) begin
         got = -1; gap = -1; rd = 'x;
         for (int i = 1; i <= 10; i++) begin
            tick();
            if (m0_ready) begin got = 0; gap = i; rd = m0_rdata; break; end
            if (m1_ready) begin got = 1; gap = i; rd = m1_rdata; break; end
         end
         checks++;
         if (got !== (k % 2)) begin errors++; $display("FAIL rr_order[%0d]: got m%0d want m%0d", k, got, k % 2); end
         checks++;
         if (gap !== ((k == 0) ? 3 : 4)) begin errors++; $display("FAIL rr_gap[%0d]: got %0d want %0d", k, gap, (k == 0) ? 3 : 4); end
         checks++;
         if (rd !== ((k % 2 == 0) ? 32'hA500_0008 : 32'hA500_0009)) begin
            errors++; $display("FAIL rr_rdata[%0d]: got %h want %h", k, rd, (k % 2 == 0) ? 32'hA500_0008 : 32'hA500_0009);
         end
      end
      drive(0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, '0, '0, '0);
      repeat (3) tick();
   endtask

   task automatic test_timeout();
      logic [31:0] rd; int lat, s0, e0; logic e;
      stuck = 1'b1;
      s0 = sel_cnt; e0 = err_cnt;
      do_access(1, 32'h20, '0, '0, 0, rd, lat, e);
      tick();
      checks++; if (lat !== 17) begin errors++; $display("FAIL to_latency: got %0d want 17", lat); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h want 00000000", rd); end
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", e); end
      checks++; if (sel_cnt - s0 !== 16) begin errors++; $display("FAIL to_sel_cycles: got %0d want 16", sel_cnt - s0); end
      checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL to_err_pulses: got %0d want 1", err_cnt - e0); end
      stuck = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_stale_ready();
      logic [31:0] rd; int lat, c0, c1; logic e;
      c0 = m0_cnt; c1 = m1_cnt;
      do_access(1, 32'h24, '0, '0, 0, rd, lat, e);
      checks++; if (sram_ready !== 1'b1) begin errors++; $display("FAIL stale_present: got %b want 1", sram_ready); end
      checks++; if (rd !== 32'hA500_0009) begin errors++; $display("FAIL stale_rdata: got %h want a5000009", rd); end
      tick();
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL stale_state: got %0d want %0d", dbg_state, IDLE); end
      checks++; if (m1_ready !== 1'b0) begin errors++; $display("FAIL stale_ready_echo: got %b want 0", m1_ready); end
      repeat (3) tick();
      checks++; if (m1_cnt - c1 !== 1) begin errors++; $display("FAIL stale_m1_pulses: got %0d want 1", m1_cnt - c1); end
      checks++; if (m0_cnt - c0 !== 0) begin errors++; $display("FAIL stale_m0_pulses: got %0d want 0", m0_cnt - c0); end
   endtask

   task automatic test_reset_mid();
      int got, lat;
      drive(1, 1'b1, 32'h24, '0, '0);
      tick();
      checks++; if (dbg_state !== ACCESS) begin errors++; $display("FAIL mid_enter: got %0d want %0d", dbg_state, ACCESS); end
      checks++; if ({sram_sel, sram_addr, sram_wstrb} !== {1'b1, 13'h0024, 4'h0}) begin
         errors++; $display("FAIL mid_latch: got sel=%b addr=%h ws=%h want 1/0024/0", sram_sel, sram_addr, sram_wstrb);
      end
      reset = 1'b1;
      tick();
      checks++;
      if ({sram_sel, sram_addr, sram_wdata, sram_wstrb, m0_ready, m1_ready, m0_rdata, m1_rdata, err} !== '0) begin
         errors++; $display("FAIL mid_reset_outputs: got sel=%b addr=%h r0=%b r1=%b err=%b, want all 0",
            sram_sel, sram_addr, m0_ready, m1_ready, err);
      end
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL mid_reset_state: got %0d want %0d", dbg_state, IDLE); end
      reset = 1'b0;
      drive(0, 1'b1, 32'h20, '0, '0);
      got = -1; lat = -1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (m0_ready) begin got = 0; lat = i; break; end
         if (m1_ready) begin got = 1; lat = i; break; end
      end
      checks++; if (got !== 0) begin errors++; $display("FAIL mid_first_grant: got m%0d want m0", got); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL mid_first_latency: got %0d want 3", lat); end
      drive(0, 1'b0, '0, '0, '0);
      got = -1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (m1_ready) begin got = 1; break; end
      end
      checks++; if (got !== 1) begin errors++; $display("FAIL mid_m1_served: got %0d want 1", got); end
      drive(1, 1'b0, '0, '0, '0);
      repeat (2) tick();
   endtask

   task automatic test_drop_valid();
      logic [31:0] rd; int lat; logic e;
      do_access(1, 32'h40, 32'h1234_5678, 4'hF, 1, rd, lat, e);
      checks++; if (lat !== 3) begin errors++; $display("FAIL drop_ready: got latency %0d want 3", lat); end
      repeat (2) tick();
      do_access(1, 32'h40, '0, '0, 0, rd, lat, e);
      checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL drop_readback: got %h want 12345678", rd); end
      repeat (2) tick();
   endtask

   initial begin
      tick();
      test_reset();
      test_write_read();
      test_round_robin();
      test_timeout();
      test_stale_ready();
      test_reset_mid();
      test_drop_valid();
      checks++; if (both_cnt !== 0) begin errors++; $display("FAIL dual_ready: got %0d cycles want 0", both_cnt); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
